program_loader: RTL and testbench

- Upstream boot stage for the single-cycle MIPS core.
- Receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory's write port at consecutive word-aligned byte addresses.
- Holds the core in reset (cpu_reset) until the whole program is written, then releases it.

---
 rtl/program_loader.sv | 118 +++++++++++
 tb/tb_program_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: turns a big-endian byte stream (16-bit word count
// header, then instruction words) into instruction-memory writes, then releases cpu_reset.
module program_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, LAST, DONE, ERR} state_t;

    state_t            state_q;
    logic [15:0]       count_q;
    logic [15:0]       word_idx_q;
    logic [15:0]       words_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       shift_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        accept;
    logic [15:0] hdr_count_d;
    logic [31:0] word_d;

    assign accept      = in_valid && in_ready;
    assign hdr_count_d = {count_q[15:8], in_data};
    assign word_d      = {shift_q, in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            words_q    <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        count_q    <= '0;
                        word_idx_q <= '0;
                        words_q    <= '0;
                        byte_idx_q <= '0;
                        shift_q    <= '0;
                        state_q    <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count_q[15:8] <= in_data;
                        state_q       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count_q    <= hdr_count_d;
                        byte_idx_q <= '0;
                        word_idx_q <= '0;
                        if (hdr_count_d == 16'd0)
                            state_q <= DONE;
                        else if (hdr_count_d > 16'(DEPTH))
                            state_q <= ERR;
                        else
                            state_q <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        shift_q    <= word_d[23:0];
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // Fourth byte completes a word: strobe the write on the next cycle.
                        if (byte_idx_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= ADDR_W'({word_idx_q, 2'b00});
                            wdata_q    <= word_d;
                            word_idx_q <= word_idx_q + 16'd1;
                            words_q    <= words_q + 16'd1;
                            if (word_idx_q == count_q - 16'd1)
                                state_q <= LAST;
                        end
                    end
                end
                LAST:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    assign busy         = in_ready || (state_q == LAST);
    assign cpu_reset    = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream-level model queues expected writes,
// an independent monitor pops and compares them on every imem_we strobe.
module tb_program_loader;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, cpu_reset, busy, done, error;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] words_loaded;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    logic [63:0] exp_q[$];
    logic [7:0]  prog[$];

    always @(posedge clk) cyc++;

    // Monitor: every write strobe must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (imem_we === 1'b1) begin
            last_we_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write actual addr=%h data=%h expected addr=%h data=%h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout byte=%h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // gapmode: 0 = back-to-back, 1 = one idle cycle between bytes, 2 = random 0..3
    task automatic run_load(input int gapmode, input int start_at, input bit do_wait);
        int cnt, n, gap;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_cpu_reset", cpu_reset, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_words", words_loaded, 0);
        cnt = int'({prog[0], prog[1]});
        if (cnt <= DEPTH)
            for (int i = 0; i < cnt; i++)
                if (4*i + 5 < prog.size())
                    exp_q.push_back({32'(4*i), prog[4*i+2], prog[4*i+3], prog[4*i+4], prog[4*i+5]});
        for (int i = 0; i < prog.size(); i++) begin
            gap = (i == 0) ? 0 : (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(3, 0));
            if (i == start_at) start = 1'b1;
            send_byte(prog[i], gap);
            start = 1'b0;
        end
        if (do_wait) begin
            n = 0;
            while (!(done === 1'b1 || error === 1'b1) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("result_timeout", n < 50, 1);
            chk("in_ready_end", in_ready, 0);
            chk("busy_end", busy, 0);
            chk("queue_drained", exp_q.size(), 0);
            if (cnt > DEPTH) begin
                chk("err_error", error, 1);
                chk("err_cpu_reset", cpu_reset, 1);
                chk("err_done", done, 0);
                chk("err_latency", n, 0);
            end else begin
                chk("done_done", done, 1);
                chk("done_cpu_reset", cpu_reset, 0);
                chk("done_error", error, 0);
                chk("done_words", words_loaded, cnt);
                if (cnt == 0) chk("empty_latency", n, 0);
                else          chk("done_after_last_we", cyc - last_we_cyc, 1);
            end
        end
    endtask

    initial begin
        logic [15:0] c16;
        int cnt;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        chk("idle_ignores_valid", in_ready, 0);
        in_valid = 1'b0;

        prog = {8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        run_load(0, -1, 1);
        chk("basic_addr_hold", imem_addr, 32'h4);
        chk("basic_wdata_hold", imem_wdata, 32'h20020005);
        run_load(1, -1, 1);
        run_load(0, 6, 1);

        prog = {8'h00, 8'h00};
        run_load(0, -1, 1);

        prog = {8'h00, 8'h41};
        run_load(0, -1, 1);
        repeat (3) @(negedge clk);
        chk("err_stays", error, 1);
        prog = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, -1, 1);

        prog = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load(0, -1, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_words", words_loaded, 0);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("midrst_queue", exp_q.size(), 0);

        for (int t = 0; t < 8; t++) begin
            cnt = (t == 0) ? DEPTH : (t == 1) ? DEPTH + 1 : int'($urandom_range(DEPTH + 3, 0));
            c16 = 16'(cnt);
            prog.delete();
            prog.push_back(c16[15:8]);
            prog.push_back(c16[7:0]);
            if (cnt <= DEPTH)
                for (int i = 0; i < 4*cnt; i++) prog.push_back(8'($urandom));
            run_load(2, -1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
